simon_key_sched: RTL and testbench
==================================

Name: simon_key_sched

Overview:
- Iterative key-expansion stage for the Simon 64/128 datapath (n=32, m=4, T=44 rounds, z-sequence z3).
- Accepts a 128-bit master key and streams the 44 round keys k[0]..k[43] one at a time over a valid/ready handshake.
- Sits directly upstream of the round-function stage; each accepted rk word is that round's k input.

Parameters:
- N, 32, word width in bits; only 32 is supported.
- ROUNDS, 44, number of round keys emitted per key load.
- Z_SEQ, 62'b11011011101011000110010111100000010010001010011100110100001111, z3 constant; the leftmost character is z3[0] and is stored at bit 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  128  master key; key_in[31:0]=k[0], [63:32]=k[1], [95:64]=k[2], [127:96]=k[3].
- start  input  1  load key_in and begin expansion; sampled only in IDLE.
- rk  output  32  current round key.
- rk_valid  output  1  rk holds round key number rk_idx.
- rk_ready  input  1  consumer accepts rk this cycle.
- rk_idx  output  6  index of the round key on rk, 0..43.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after k[43] is accepted.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- On reset, all registers and outputs are 0 and the state is IDLE.
- Storage:
  - Key window of four words w0..w3.
  - 62-bit z register, rotated right by 1 per step, so z[0] = z3[i mod 62].
  - 6-bit counter idx.
- Outputs are driven from registers:
  - rk = w0, rk_idx = idx.
  - rk_valid = busy = (state == RUN).
- IDLE:
  - rk_valid = 0.
  - On start=1, the next edge loads w0..w3 = key_in words 0..3, z = Z_SEQ, idx = 0, and the state goes to RUN.
- RUN:
  - Handshake fires when rk_valid & rk_ready.
  - On a handshake, compute the new word:
    - tmp = ror3(w3) ^ w1.
    - tmp = tmp ^ ror1(tmp).
    - new = ~w0 ^ tmp ^ {31'b0, z[0]} ^ 32'h3.
  - Then shift the window (w0<=w1, w1<=w2, w2<=w3, w3<=new), rotate z, and increment idx.
  - With no handshake, all state holds. rk, rk_idx and rk_valid stay stable indefinitely under backpressure.
- Termination: a handshake when idx == ROUNDS-1 sends the state to IDLE and asserts done=1 for exactly the following cycle.
  - rk_valid is 0 in that cycle.
  - The window update on this final handshake is don't-care.
- Latency and throughput:
  - k[0] is valid in the cycle after start is sampled.
  - One key per cycle with rk_ready held high, so k[43] is valid 44 cycles after start.
  - done is high on cycle 45.
- start while in RUN is ignored; there is no restart and no corruption.
- start in the same cycle done is high: the block is in IDLE, so start is honoured normally.
- A rst asserted mid-run takes priority over everything. The next cycle is IDLE with all outputs 0, and no done pulse is produced.
- Arithmetic is bitwise only and is modulo 2^32; there is no carry.
- z never wraps, because 44 < 62. The rotation is still implemented for generality.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst for 2 cycles, then idle.
  - Required: rk_valid=0, busy=0, done=0, rk=0, rk_idx=0.
- Spec key vector, first keys:
  - Stimulus: key_in = 128'h1b1a1918_13121110_0b0a0908_03020100, start for 1 cycle, rk_ready=1.
  - Required: rk = 03020100, 0b0a0908, 13121110, 1b1a1918, 70a011c3 on consecutive cycles, with rk_idx = 0..4.
- Full run:
  - Stimulus: same key, rk_ready=1.
  - Required: exactly 44 valid beats, then done pulses once and busy drops.
  - Required: a round-function reference model fed these keys with plaintext 64'h656b696c_20646e75 yields 64'h44c8fc20_b9dfa07a.
- Backpressure:
  - Stimulus: drop rk_ready for 5 cycles while rk_idx=4.
  - Required: rk holds 70a011c3 and rk_idx holds 4; the sequence resumes unchanged, with the same 44 keys as the unstalled run.
- start during RUN:
  - Stimulus: pulse start with a different key at rk_idx=10.
  - Required: the output key stream is identical to the undisturbed run.
- Reset mid-run:
  - Stimulus: rst at rk_idx=20.
  - Required: next cycle rk_valid=0 and no done pulse; a fresh start then reproduces k[0]=03020100.

Source files
------------

// File: rtl/simon_key_sched.sv
// Simon 64/128 key expansion: loads a 128-bit master key and streams round
// keys k[0]..k[ROUNDS-1] one per accepted valid/ready beat.
module simon_key_sched #(
  parameter int          N      = 32,
  parameter int          ROUNDS = 44,
  parameter logic [61:0] Z_SEQ  = 62'b11011011101011000110010111100000010010001010011100110100001111
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [127:0]   key_in,
  input  logic           start,
  output logic [N-1:0]   rk,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic [5:0]     rk_idx,
  output logic           busy,
  output logic           done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The literal reads z3[0] first, so it is bit-reversed to put z3[0] at bit 0.
  function automatic logic [61:0] rev62(input logic [61:0] v);
    logic [61:0] r;
    for (int i = 0; i < 62; i++) r[i] = v[61-i];
    return r;
  endfunction

  localparam logic [61:0] Z_INIT = rev62(Z_SEQ);
  localparam logic [5:0]  LAST_IDX = 6'(ROUNDS - 1);

  function automatic logic [N-1:0] ror1(input logic [N-1:0] x);
    return {x[0], x[N-1:1]};
  endfunction

  function automatic logic [N-1:0] ror3(input logic [N-1:0] x);
    return {x[2:0], x[N-1:3]};
  endfunction

  state_t       state_q, state_d;
  logic [N-1:0] w0_q, w1_q, w2_q, w3_q;
  logic [61:0]  z_q;
  logic [5:0]   idx_q;
  logic         done_q;

  logic         fire;
  logic         last_beat;
  logic [N-1:0] tmp_a, tmp_b, new_word;

  assign fire      = (state_q == RUN) && rk_ready;
  assign last_beat = fire && (idx_q == LAST_IDX);

  always_comb begin
    tmp_a    = ror3(w3_q) ^ w1_q;
    tmp_b    = tmp_a ^ ror1(tmp_a);
    new_word = ~w0_q ^ tmp_b ^ {{(N-1){1'b0}}, z_q[0]} ^ N'(3);
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w0_q   <= '0;
      w1_q   <= '0;
      w2_q   <= '0;
      w3_q   <= '0;
      z_q    <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_beat;
      if (state_q == IDLE) begin
        if (start) begin
          w0_q  <= key_in[31:0];
          w1_q  <= key_in[63:32];
          w2_q  <= key_in[95:64];
          w3_q  <= key_in[127:96];
          z_q   <= Z_INIT;
          idx_q <= '0;
        end
      end else if (fire) begin
        // Window slides one word; the update on the final beat is never observed.
        w0_q  <= w1_q;
        w1_q  <= w2_q;
        w2_q  <= w3_q;
        w3_q  <= new_word;
        z_q   <= {z_q[0], z_q[61:1]};
        idx_q <= idx_q + 6'd1;
      end
    end
  end

  assign rk       = w0_q;
  assign rk_idx   = idx_q;
  assign rk_valid = (state_q == RUN);
  assign busy     = (state_q == RUN);
  assign done     = done_q;

endmodule

// File: tb/tb_simon_key_sched.sv
// Directed bench for simon_key_sched: known-answer keys, full-run ciphertext
// check, backpressure, start during a run and reset mid-run.
module tb_simon_key_sched;

  localparam logic [127:0] KEY   = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [61:0]  Z_LIT = 62'b11011011101011000110010111100000010010001010011100110100001111;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         start;
  logic [31:0]  rk;
  logic         rk_valid;
  logic         rk_ready;
  logic [5:0]   rk_idx;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_k [44];
  logic [31:0] got_k [44];

  simon_key_sched dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .start    (start),
    .rk       (rk),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_idx   (rk_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  // Key schedule written straight from the recurrence; z3[i] is the i-th literal character.
  task automatic build_model(input logic [127:0] key);
    logic [31:0] t;
    for (int i = 0; i < 4; i++) exp_k[i] = key[32*i +: 32];
    for (int i = 0; i < 40; i++) begin
      t = rol(exp_k[i+3], 29) ^ exp_k[i+1];
      t = t ^ rol(t, 31);
      exp_k[i+4] = ~exp_k[i] ^ t ^ {31'b0, Z_LIT[61-i]} ^ 32'h3;
    end
  endtask

  function automatic logic [63:0] encrypt(input logic [63:0] pt);
    logic [31:0] x, y, t;
    x = pt[63:32];
    y = pt[31:0];
    for (int i = 0; i < 44; i++) begin
      t = x;
      x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ got_k[i];
      y = t;
    end
    return {x, y};
  endfunction

  // One expansion. stall_idx/disturb_idx/rst_idx < 0 disables that feature.
  task automatic run(input logic [127:0] key, input int stall_idx, input int stall_len,
                     input int disturb_idx, input int rst_idx);
    int  beats, cyc, stalled;
    bit  disturbed, finished;
    beats = 0; cyc = 0; stalled = 0; disturbed = 0; finished = 0;
    for (int i = 0; i < 44; i++) got_k[i] = 32'h0;
    @(negedge clk);
    key_in   = key;
    start    = 1'b1;
    rk_ready = 1'b1;
    for (int n = 0; n < 300 && !finished; n++) begin
      @(negedge clk);
      cyc++;
      start  = 1'b0;
      key_in = key;
      if (done) begin
        finished = 1;
        check("done_beats", 128'(beats), 128'd44);
        check("done_cycle", 128'(cyc), 128'(45 + ((stall_idx >= 0) ? stall_len : 0)));
        check("done_busy", {126'b0, busy, rk_valid}, 128'd0);
        @(negedge clk);
        check("done_once", {127'b0, done}, 128'd0);
      end else if (rk_valid) begin
        if (rst_idx >= 0 && int'(rk_idx) == rst_idx) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          check("rst_outs", {rk, rk_idx, rk_valid, busy, done}, 128'd0);
          for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            if (done || rk_valid) check("rst_quiet", {126'b0, done, rk_valid}, 128'd0);
          end
          return;
        end
        if (stall_idx >= 0 && int'(rk_idx) == stall_idx && stalled < stall_len) begin
          if (stalled > 0) check("stall_hold", {rk_idx, rk}, {6'(stall_idx), exp_k[stall_idx]});
          rk_ready = 1'b0;
          stalled++;
        end else begin
          rk_ready = 1'b1;
          check("beat_idx", 128'(rk_idx), 128'(beats));
          if (beats < 44) got_k[beats] = rk;
          beats++;
        end
        if (disturb_idx >= 0 && int'(rk_idx) == disturb_idx && !disturbed) begin
          key_in    = ~key;
          start     = 1'b1;
          disturbed = 1;
        end
      end
    end
    if (!finished) check("done_timeout", 128'd0, 128'd1);
    rk_ready = 1'b1;
    for (int i = 0; i < 44; i++) check($sformatf("k%0d", i), 128'(got_k[i]), 128'(exp_k[i]));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outs", {rk, rk_idx, rk_valid, busy, done}, 128'd0);

    build_model(KEY);
    check("model_k4", 128'(exp_k[4]), 128'h70a011c3);

    // Undisturbed run with hand-computed first keys and the known ciphertext.
    run(KEY, -1, 0, -1, -1);
    check("k0_hand", 128'(got_k[0]), 128'h03020100);
    check("k1_hand", 128'(got_k[1]), 128'h0b0a0908);
    check("k2_hand", 128'(got_k[2]), 128'h13121110);
    check("k3_hand", 128'(got_k[3]), 128'h1b1a1918);
    check("k4_hand", 128'(got_k[4]), 128'h70a011c3);
    check("cipher", 128'(encrypt(64'h656b696c_20646e75)), 128'h44c8fc20_b9dfa07a);

    run(KEY, 4, 5, -1, -1);
    check("stall_cipher", 128'(encrypt(64'h656b696c_20646e75)), 128'h44c8fc20_b9dfa07a);

    run(KEY, -1, 0, 10, -1);

    run(KEY, -1, 0, -1, 20);

    run(KEY, -1, 0, -1, -1);
    check("fresh_k0", 128'(got_k[0]), 128'h03020100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
